// File: rtl/fir_tone_if.sv
// Control/status and sample bus between the tone generator and its consumer.
interface fir_tone_if #(
    parameter int PHASE_W = 24,
    parameter int DIV_W   = 8,
    parameter int CNT_W   = 16
);
    logic               start;
    logic               stop;
    logic [PHASE_W-1:0] ftw_a;
    logic [PHASE_W-1:0] ftw_b;
    logic [DIV_W-1:0]   rate_div;
    logic [CNT_W-1:0]   n_samples;
    logic               busy;
    logic               done;
    logic               en;
    logic [11:0]        xin;

    modport master (
        output start, stop, ftw_a, ftw_b, rate_div, n_samples,
        input  busy, done, en, xin
    );

    modport slave (
        input  start, stop, ftw_a, ftw_b, rate_div, n_samples,
        output busy, done, en, xin
    );
endinterface

// File: rtl/fir_tone_gen.sv
// Two-tone NCO sample source producing offset-binary 12-bit xin with an en strobe.
// Optional LFSR dither with output saturation when FIR_TONE_DITHER_EN is defined.
module fir_tone_gen #(
    parameter int PHASE_W = 24,
    parameter int DIV_W   = 8,
    parameter int CNT_W   = 16
) (
    input logic       clk,
    input logic       rst,
    fir_tone_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_tick;
    logic                w_load;
    logic                w_busy;
    logic                w_done;
    logic [PHASE_W-1:0]  r_ftw_a;
    logic [PHASE_W-1:0]  r_ftw_b;
    logic [PHASE_W-1:0]  r_phase_a;
    logic [PHASE_W-1:0]  r_phase_b;
    logic [DIV_W-1:0]    r_rate_div;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [CNT_W-1:0]    r_n;
    logic [CNT_W-1:0]    r_issued;
    logic [CNT_W:0]      w_issued_inc;
    logic signed [10:0]  w_sin_a;
    logic signed [10:0]  w_sin_b;
    logic signed [10:0]  r_sin_a_p1;
    logic signed [10:0]  r_sin_b_p1;
    logic                r_vld_p1;
    logic                r_vld_p2;
    logic [11:0]         w_xin_p1;
    logic [11:0]         r_xin_p2;

    function automatic logic [9:0] quarter_rom(input logic [6:0] idx);
        logic [9:0] v;
        case (idx)
            7'd0:  v = 10'd0;    7'd1:  v = 10'd25;   7'd2:  v = 10'd50;   7'd3:  v = 10'd75;
            7'd4:  v = 10'd100;  7'd5:  v = 10'd125;  7'd6:  v = 10'd150;  7'd7:  v = 10'd175;
            7'd8:  v = 10'd200;  7'd9:  v = 10'd224;  7'd10: v = 10'd249;  7'd11: v = 10'd273;
            7'd12: v = 10'd297;  7'd13: v = 10'd321;  7'd14: v = 10'd345;  7'd15: v = 10'd368;
            7'd16: v = 10'd391;  7'd17: v = 10'd415;  7'd18: v = 10'd437;  7'd19: v = 10'd460;
            7'd20: v = 10'd482;  7'd21: v = 10'd504;  7'd22: v = 10'd526;  7'd23: v = 10'd547;
            7'd24: v = 10'd568;  7'd25: v = 10'd589;  7'd26: v = 10'd609;  7'd27: v = 10'd629;
            7'd28: v = 10'd649;  7'd29: v = 10'd668;  7'd30: v = 10'd687;  7'd31: v = 10'd705;
            7'd32: v = 10'd723;  7'd33: v = 10'd741;  7'd34: v = 10'd758;  7'd35: v = 10'd775;
            7'd36: v = 10'd791;  7'd37: v = 10'd806;  7'd38: v = 10'd822;  7'd39: v = 10'd836;
            7'd40: v = 10'd851;  7'd41: v = 10'd864;  7'd42: v = 10'd877;  7'd43: v = 10'd890;
            7'd44: v = 10'd902;  7'd45: v = 10'd914;  7'd46: v = 10'd925;  7'd47: v = 10'd935;
            7'd48: v = 10'd945;  7'd49: v = 10'd954;  7'd50: v = 10'd963;  7'd51: v = 10'd971;
            7'd52: v = 10'd979;  7'd53: v = 10'd986;  7'd54: v = 10'd992;  7'd55: v = 10'd998;
            7'd56: v = 10'd1003; 7'd57: v = 10'd1008; 7'd58: v = 10'd1012; 7'd59: v = 10'd1015;
            7'd60: v = 10'd1018; 7'd61: v = 10'd1020; 7'd62: v = 10'd1022; 7'd63: v = 10'd1023;
            7'd64: v = 10'd1023;
            default: v = 10'd0;
        endcase
        return v;
    endfunction

    // Odd quadrants mirror the index, the lower half-circle negates the magnitude.
    function automatic logic signed [10:0] sine_of(input logic [7:0] p);
        logic [6:0] idx;
        logic [9:0] mag;
        idx = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
        mag = quarter_rom(idx);
        return p[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    assign w_sin_a      = sine_of(r_phase_a[PHASE_W-1 -: 8]);
    assign w_sin_b      = sine_of(r_phase_b[PHASE_W-1 -: 8]);
    assign w_issued_inc = {1'b0, r_issued} + {{CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_tick = 1'b0;
        w_load = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (bus.stop) begin
                    w_next = S_DRAIN;
                end else if (r_div_cnt == '0) begin
                    w_tick = 1'b1;
                    if (r_n != '0 && w_issued_inc == {1'b0, r_n}) w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (!r_vld_p1 && !r_vld_p2) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef FIR_TONE_DITHER_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0]        r_lfsr;
    logic               r_dith_p1;
    logic signed [12:0] w_sum_p1;
    logic signed [12:0] w_dsum_p1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [11:0] sat_u12(input logic signed [12:0] d);
        return (d < 0) ? 12'd0 : d[11:0];
    endfunction

    assign w_sum_p1  = {{2{r_sin_a_p1[10]}}, r_sin_a_p1} + {{2{r_sin_b_p1[10]}}, r_sin_b_p1}
                     + 13'sd2048;
    assign w_dsum_p1 = w_sum_p1 + (r_dith_p1 ? 13'sd1 : -13'sd1);
    assign w_xin_p1  = sat_u12(w_dsum_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr    <= LFSR_SEED;
            r_dith_p1 <= 1'b0;
        end else if (w_load) begin
            r_lfsr    <= LFSR_SEED;
        end else if (w_tick) begin
            r_lfsr    <= lfsr_next(r_lfsr);
            r_dith_p1 <= r_lfsr[0];
        end
    end
`else
    // Undithered sum spans 2..4094, so modulo-4096 arithmetic is exact here.
    assign w_xin_p1 = {r_sin_a_p1[10], r_sin_a_p1} + {r_sin_b_p1[10], r_sin_b_p1} + 12'd2048;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ftw_a    <= '0;
            r_ftw_b    <= '0;
            r_rate_div <= '0;
            r_n        <= '0;
            r_phase_a  <= '0;
            r_phase_b  <= '0;
            r_div_cnt  <= '0;
            r_issued   <= '0;
            r_sin_a_p1 <= '0;
            r_sin_b_p1 <= '0;
            r_vld_p1   <= 1'b0;
            r_xin_p2   <= 12'h800;
            r_vld_p2   <= 1'b0;
        end else begin
            if (w_load) begin
                r_ftw_a    <= bus.ftw_a;
                r_ftw_b    <= bus.ftw_b;
                r_rate_div <= bus.rate_div;
                r_n        <= bus.n_samples;
                r_phase_a  <= '0;
                r_phase_b  <= '0;
                r_div_cnt  <= '0;
                r_issued   <= '0;
            end else if (w_tick) begin
                r_phase_a  <= r_phase_a + r_ftw_a;
                r_phase_b  <= r_phase_b + r_ftw_b;
                r_div_cnt  <= r_rate_div;
                if (r_issued != '1) r_issued <= w_issued_inc[CNT_W-1:0];
            end else if (r_state == S_RUN && r_div_cnt != '0) begin
                r_div_cnt  <= r_div_cnt - DIV_W'(1);
            end

            // stage 1: LUT outputs
            r_vld_p1 <= w_tick;
            if (w_tick) begin
                r_sin_a_p1 <= w_sin_a;
                r_sin_b_p1 <= w_sin_b;
            end

            // stage 2: summed, offset sample and its strobe
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) r_xin_p2 <= w_xin_p1;
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.en   = r_vld_p2;
    assign bus.xin  = r_xin_p2;

endmodule

// File: tb/tb_fir_tone_gen.sv
// Directed bench for fir_tone_gen: reset, fixed-length runs, continuous/stop, ignored controls.
module tb_fir_tone_gen;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fir_tone_if u_if ();

    fir_tone_gen u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives config with a start pulse in the current cycle; returns one cycle later.
    task automatic launch(input logic [23:0] fa, input logic [23:0] fb,
                          input logic [7:0] rd, input logic [15:0] n);
        u_if.ftw_a     = fa;
        u_if.ftw_b     = fb;
        u_if.rate_div  = rd;
        u_if.n_samples = n;
        u_if.start     = 1'b1;
        step();
        u_if.start     = 1'b0;
    endtask

    initial begin
        int seen;
        int dn;
        int t3_exp[4];
        int t4_exp[3];
        t3_exp = '{2048, 4094, 2048, 2};
        t4_exp = '{2048, 2073, 2098};

        rst = 1'b1;
        u_if.start = 1'b0; u_if.stop = 1'b0;
        u_if.ftw_a = '0; u_if.ftw_b = '0; u_if.rate_div = '0; u_if.n_samples = '0;
        step();
        chk("rst_busy", u_if.busy, 0);
        chk("rst_done", u_if.done, 0);
        chk("rst_en",   u_if.en,   0);
        chk("rst_xin",  u_if.xin,  12'h800);
        step();
        rst = 1'b0;
        step();

        // T2: quarter-turn tone, back-to-back samples
        launch(24'h400000, 24'h0, 8'd0, 16'd4);
        chk("t2_busy_c1", u_if.busy, 1);
        chk("t2_en_c1", u_if.en, 0);
        step(); chk("t2_en_c2", u_if.en, 0);
        step(); chk("t2_en_c3", u_if.en, 1); chk("t2_xin0", u_if.xin, 2048);
        step(); chk("t2_en_c4", u_if.en, 1); chk("t2_xin1", u_if.xin, 3071);
        step(); chk("t2_en_c5", u_if.en, 1); chk("t2_xin2", u_if.xin, 2048);
        step(); chk("t2_en_c6", u_if.en, 1); chk("t2_xin3", u_if.xin, 1025);
        step(); chk("t2_en_c7", u_if.en, 0); chk("t2_done_c7", u_if.done, 1);
        chk("t2_busy_c7", u_if.busy, 1);
        step(); chk("t2_done_c8", u_if.done, 0); chk("t2_busy_c8", u_if.busy, 0);
        chk("t2_xin_hold", u_if.xin, 1025);

        // T3: both tones, one sample every 4 clocks
        launch(24'h400000, 24'h400000, 8'd3, 16'd4);
        seen = 0;
        for (int cyc = 2; cyc <= 19; cyc++) begin
            step();
            if (cyc == 3 || cyc == 7 || cyc == 11 || cyc == 15) begin
                chk("t3_en_slot", u_if.en, 1);
                if (seen < 4) chk("t3_xin", u_if.xin, t3_exp[seen]);
            end else begin
                chk("t3_en_gap", u_if.en, 0);
            end
            if (u_if.en) seen++;
            if (cyc == 16) chk("t3_done", u_if.done, 1);
        end
        chk("t3_en_count", seen, 4);
        chk("t3_busy_end", u_if.busy, 0);

        // T4: continuous run, stop after the tenth sample
        launch(24'h010000, 24'h0, 8'd0, 16'd0);
        seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            step();
            if (u_if.en) begin
                if (seen < 3) chk("t4_xin_head", u_if.xin, t4_exp[seen]);
                seen++;
                if (seen == 10) break;
            end
        end
        chk("t4_en_before_stop", seen, 10);
        chk("t4_xin9", u_if.xin, 2272);
        u_if.stop = 1'b1;
        step();
        u_if.stop = 1'b0;
        chk("t4_tail_en", u_if.en, 1);
        chk("t4_tail_xin", u_if.xin, 2297);
        chk("t4_tail_nodone", u_if.done, 0);
        step();
        chk("t4_done", u_if.done, 1);
        chk("t4_done_en", u_if.en, 0);
        seen = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            step();
            if (u_if.en) seen++;
        end
        chk("t4_no_en_after_done", seen, 0);
        chk("t4_idle", u_if.busy, 0);

        // T5: start while busy is ignored, config changes ignored
        launch(24'h400000, 24'h0, 8'd0, 16'd4);
        u_if.ftw_a = 24'h200000; u_if.rate_div = 8'd5; u_if.n_samples = 16'd9;
        u_if.start = 1'b1;
        step();
        u_if.start = 1'b0;
        step(); chk("t5_xin0", u_if.xin, 2048);
        step(); chk("t5_xin1", u_if.xin, 3071);
        step(); chk("t5_xin2", u_if.xin, 2048);
        step(); chk("t5_xin3", u_if.xin, 1025); chk("t5_en3", u_if.en, 1);
        step(); chk("t5_done", u_if.done, 1);
        step(); chk("t5_idle", u_if.busy, 0);
        u_if.stop = 1'b1;
        step();
        u_if.stop = 1'b0;
        chk("t5_stop_idle_busy", u_if.busy, 0);
        chk("t5_stop_idle_done", u_if.done, 0);
        step();
        chk("t5_stop_idle_done2", u_if.done, 0);

        // T6: stop in the first RUN cycle
        launch(24'h400000, 24'h0, 8'd0, 16'd4);
        u_if.stop = 1'b1;
        step();
        u_if.stop = 1'b0;
        chk("t6_done", u_if.done, 1);
        chk("t6_en", u_if.en, 0);
        seen = 0;
        dn = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            step();
            if (u_if.en) seen++;
            if (u_if.done) dn++;
        end
        chk("t6_en_count", seen, 0);
        chk("t6_extra_done", dn, 0);
        chk("t6_idle", u_if.busy, 0);

        // T1: asynchronous reset in the middle of a continuous run
        launch(24'h010000, 24'h0, 8'd0, 16'd0);
        step(); step(); step();
        chk("t1_pre_en", u_if.en, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_en", u_if.en, 0);
        chk("t1_done", u_if.done, 0);
        chk("t1_busy", u_if.busy, 0);
        chk("t1_xin", u_if.xin, 12'h800);
        step(); step();
        rst = 1'b0;
        seen = 0;
        dn = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            step();
            if (u_if.en) seen++;
            if (u_if.busy || u_if.done) dn++;
        end
        chk("t1_post_en", seen, 0);
        chk("t1_post_idle", dn, 0);
        launch(24'h400000, 24'h0, 8'd0, 16'd4);
        step(); step(); step();
        chk("t1_restart_xin1", u_if.xin, 3071);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
